// File: rtl/alarm_clock_controller.sv
// Alarm-clock sequencing FSM: turns keypad digits and ALARM/TIME buttons into
// display selects, a shifting digit buffer, and one-cycle register load strobes.
//
// state            | meaning
// SHOW_TIME        | idle, display shows current time
// KEY_STORED       | digit just captured into key_buffer (shift strobe)
// KEY_WAITED       | waiting for the digit key to be released
// KEY_ENTRY        | entry in progress, waiting for next digit or a button
// SHOW_ALARM       | ALARM held, display shows alarm time
// SET_ALARM_TIME   | one-cycle alarm register load
// SET_CURRENT_TIME | one-cycle current-time register load
module alarm_clock_controller #(
    parameter int unsigned DIGITS      = 1,
    parameter int unsigned TIMEOUT_SEC = 10,
    parameter logic [3:0]  NOKEY       = 4'hA
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  one_second,
    input  logic [3:0]            key,
    input  logic                  alarm_button,
    input  logic                  time_button,
    output logic [4*DIGITS-1:0]   key_buffer,
    output logic                  show_a,
    output logic                  show_new_time,
    output logic                  load_new_a,
    output logic                  load_new_c,
    output logic                  shift
);

    typedef enum logic [2:0] {
        SHOW_TIME,
        KEY_STORED,
        KEY_WAITED,
        KEY_ENTRY,
        SHOW_ALARM,
        SET_ALARM_TIME,
        SET_CURRENT_TIME
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT_SEC[7:0];

    state_t               state;
    state_t               state_next;
    logic [7:0]           timer;
    logic                 timeout;
    logic                 counting;
    logic                 digit;
    logic [4*DIGITS-1:0]  buffer_next;

    // Codes above 9 are treated exactly like the idle code.
    assign digit    = (key <= 4'd9) && (key != NOKEY);
    assign timeout  = (timer == TIMEOUT_CNT);
    assign counting = (state == KEY_WAITED) || (state == KEY_ENTRY);

    generate
        if (DIGITS == 1) begin : g_single
            assign buffer_next = key;
        end else begin : g_multi
            assign buffer_next = {key_buffer[4*DIGITS-5:0], key};
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SHOW_TIME;
        end else begin
            state <= state_next;
        end
    end

    // Digit is captured on the edge entering KEY_STORED, so it is already
    // visible on key_buffer while shift is high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_buffer <= '0;
        end else if (state_next == KEY_STORED) begin
            key_buffer <= buffer_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer <= 8'd0;
        end else if (!counting) begin
            timer <= 8'd0;
        end else if (one_second && !timeout) begin
            timer <= timer + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SHOW_TIME: begin
                if (alarm_button) begin
                    state_next = SHOW_ALARM;
                end else if (digit) begin
                    state_next = KEY_STORED;
                end
            end
            KEY_STORED: begin
                state_next = KEY_WAITED;
            end
            KEY_WAITED: begin
                if (!digit) begin
                    state_next = KEY_ENTRY;
                end else if (timeout) begin
                    state_next = SHOW_TIME;
                end
            end
            KEY_ENTRY: begin
                if (alarm_button) begin
                    state_next = SET_ALARM_TIME;
                end else if (time_button) begin
                    state_next = SET_CURRENT_TIME;
                end else if (digit) begin
                    state_next = KEY_STORED;
                end else if (timeout) begin
                    state_next = SHOW_TIME;
                end
            end
            SHOW_ALARM: begin
                if (!alarm_button) begin
                    state_next = SHOW_TIME;
                end
            end
            SET_ALARM_TIME:   state_next = SHOW_TIME;
            SET_CURRENT_TIME: state_next = SHOW_TIME;
            default:          state_next = SHOW_TIME;
        endcase
    end

    always_comb begin
        show_a        = 1'b0;
        show_new_time = 1'b0;
        load_new_a    = 1'b0;
        load_new_c    = 1'b0;
        shift         = 1'b0;
        case (state)
            KEY_STORED: begin
                show_new_time = 1'b1;
                shift         = 1'b1;
            end
            KEY_WAITED:       show_new_time = 1'b1;
            KEY_ENTRY:        show_new_time = 1'b1;
            SHOW_ALARM:       show_a        = 1'b1;
            SET_ALARM_TIME:   load_new_a    = 1'b1;
            SET_CURRENT_TIME: load_new_c    = 1'b1;
            default: begin
                show_a        = 1'b0;
                show_new_time = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alarm_clock_controller.sv
// Directed bench for alarm_clock_controller (DIGITS=2, TIMEOUT_SEC=10); strobes
// are checked by a queue-driven monitor, display levels by direct checks.
module tb_alarm_clock_controller;

    localparam logic [3:0] NK = 4'hA;
    localparam logic [2:0] EV_SHIFT  = 3'b100;
    localparam logic [2:0] EV_LOAD_A = 3'b010;
    localparam logic [2:0] EV_LOAD_C = 3'b001;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] kb;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       one_second;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
    logic [7:0] key_buffer;
    logic       show_a;
    logic       show_new_time;
    logic       load_new_a;
    logic       load_new_c;
    logic       shift;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    alarm_clock_controller #(
        .DIGITS(2),
        .TIMEOUT_SEC(10),
        .NOKEY(4'hA)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .one_second(one_second),
        .key(key),
        .alarm_button(alarm_button),
        .time_button(time_button),
        .key_buffer(key_buffer),
        .show_a(show_a),
        .show_new_time(show_new_time),
        .load_new_a(load_new_a),
        .load_new_c(load_new_c),
        .shift(shift)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic expect_ev(input logic [2:0] kind, input logic [7:0] kb);
        exp_t e;
        e.kind = kind;
        e.kb   = kb;
        exp_q.push_back(e);
    endtask

    task automatic pulse_sec();
        one_second = 1'b1;
        step(1);
        one_second = 1'b0;
        step(1);
    endtask

    initial begin
        reset_n      = 1'b0;
        one_second   = 1'b0;
        key          = NK;
        alarm_button = 1'b0;
        time_button  = 1'b0;

        fork
            begin : stimulus
                // reset
                step(2);
                chk("rst_key_buffer", key_buffer, 8'h00);
                chk("rst_outputs", {3'b0, show_a, show_new_time, load_new_a, load_new_c, shift}, 8'h00);
                reset_n = 1'b1;
                step(1);
                chk("post_rst_show_new_time", {7'b0, show_new_time}, 8'h00);

                // digit entry and alarm load
                key = 4'd7;
                expect_ev(EV_SHIFT, 8'h07);
                step(1);
                chk("d7_show_new_time", {7'b0, show_new_time}, 8'h01);
                chk("d7_key_buffer", key_buffer, 8'h07);
                step(2);
                chk("d7_held_show_new_time", {7'b0, show_new_time}, 8'h01);
                key = NK;
                step(1);
                chk("entry_show_new_time", {7'b0, show_new_time}, 8'h01);
                alarm_button = 1'b1;
                expect_ev(EV_LOAD_A, 8'h07);
                step(1);
                chk("load_a_high", {7'b0, load_new_a}, 8'h01);
                alarm_button = 1'b0;
                step(1);
                chk("load_a_low", {7'b0, load_new_a}, 8'h00);
                chk("after_load_a_show_new_time", {7'b0, show_new_time}, 8'h00);

                // two-digit time load
                key = 4'd1;
                expect_ev(EV_SHIFT, 8'h71);
                step(1);
                key = NK;
                step(2);
                key = 4'd2;
                expect_ev(EV_SHIFT, 8'h12);
                step(1);
                chk("d12_key_buffer", key_buffer, 8'h12);
                key = NK;
                step(2);
                time_button = 1'b1;
                expect_ev(EV_LOAD_C, 8'h12);
                step(1);
                chk("load_c_high", {7'b0, load_new_c}, 8'h01);
                chk("load_c_no_load_a", {7'b0, load_new_a}, 8'h00);
                time_button = 1'b0;
                step(1);
                chk("load_c_low", {7'b0, load_new_c}, 8'h00);
                chk("after_load_c_show_new_time", {7'b0, show_new_time}, 8'h00);

                // timeout
                key = 4'd5;
                expect_ev(EV_SHIFT, 8'h25);
                step(1);
                key = NK;
                step(2);
                repeat (9) pulse_sec();
                chk("to_9_pulses", {7'b0, show_new_time}, 8'h01);
                one_second = 1'b1;
                step(1);
                one_second = 1'b0;
                chk("to_10th_edge", {7'b0, show_new_time}, 8'h01);
                step(1);
                chk("to_expired", {7'b0, show_new_time}, 8'h00);
                chk("to_key_buffer_kept", key_buffer, 8'h25);

                // count restarts on a new digit
                key = 4'd6;
                expect_ev(EV_SHIFT, 8'h56);
                step(1);
                key = NK;
                step(2);
                repeat (9) pulse_sec();
                key = 4'd4;
                expect_ev(EV_SHIFT, 8'h64);
                step(1);
                key = NK;
                step(2);
                repeat (9) pulse_sec();
                chk("restart_still_entry", {7'b0, show_new_time}, 8'h01);
                pulse_sec();
                chk("restart_expired", {7'b0, show_new_time}, 8'h00);
                chk("restart_key_buffer", key_buffer, 8'h64);

                // show alarm with a digit held
                key = 4'd3;
                alarm_button = 1'b1;
                step(1);
                for (int i = 0; i < 20; i++) begin
                    chk("show_a_hold", {7'b0, show_a}, 8'h01);
                    if (i < 19) step(1);
                end
                chk("show_a_no_entry", {7'b0, show_new_time}, 8'h00);
                alarm_button = 1'b0;
                key = NK;
                step(1);
                chk("show_a_released", {7'b0, show_a}, 8'h00);
                chk("show_a_release_key_buffer", key_buffer, 8'h64);

                // reset during a strobe
                key = 4'd8;
                expect_ev(EV_SHIFT, 8'h48);
                step(1);
                key = NK;
                step(2);
                alarm_button = 1'b1;
                step(1);
                reset_n = 1'b0;
                #1;
                chk("rst_strobe_load_a", {7'b0, load_new_a}, 8'h00);
                alarm_button = 1'b0;
                step(2);
                reset_n = 1'b1;
                step(1);
                chk("rst_strobe_key_buffer", key_buffer, 8'h00);
                chk("rst_strobe_outputs", {3'b0, show_a, show_new_time, load_new_a, load_new_c, shift}, 8'h00);
                step(2);
            end
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clock);
                    if (reset_n && (shift || load_new_a || load_new_c)) begin
                        vectors++;
                        if (exp_q.size() == 0) begin
                            miscompares++;
                            $display("FAIL unexpected_strobe: got %b kb=%h expected none",
                                     {shift, load_new_a, load_new_c}, key_buffer);
                        end else begin
                            e = exp_q.pop_front();
                            if ({shift, load_new_a, load_new_c} !== e.kind || key_buffer !== e.kb
                                || show_new_time !== e.kind[2]) begin
                                miscompares++;
                                $display("FAIL strobe: got %b kb=%h snt=%b expected %b kb=%h snt=%b",
                                         {shift, load_new_a, load_new_c}, key_buffer, show_new_time,
                                         e.kind, e.kb, e.kind[2]);
                            end
                        end
                    end
                end
            end
        join_any
        disable fork;

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_strobes: got %0d left in queue expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alarm_clock_controller.md
Name: alarm_clock_controller

Overview:
- Moore FSM that sequences the alarm-clock display/alarm datapath.
- Decodes keypad digits and the ALARM/TIME buttons into display selects (show_a, show_new_time), a keypad digit buffer, and one-cycle load strobes for the alarm and current-time registers.
- Aborts key entry after TIMEOUT_SEC seconds of inactivity.
- Sits between the keypad/button debouncers and the display driver plus time/alarm registers.

Parameters:
- DIGITS, 1: number of 4-bit BCD digits held in the key buffer.
- TIMEOUT_SEC, 10: one_second pulses of inactivity in key entry before returning to SHOW_TIME; range 1..255.
- NOKEY, 4'hA: keypad code meaning "no key pressed".

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- one_second  input  1  one-cycle-wide tick, once per second.
- key  input  4  debounced keypad code: 0..9 are digits, NOKEY means idle, other codes are ignored as NOKEY.
- alarm_button  input  1  level; held high while ALARM is pressed.
- time_button  input  1  level; held high while TIME is pressed.
- key_buffer  output  4*DIGITS  entered digits; newest digit in [3:0].
- show_a  output  1  display selects alarm time.
- show_new_time  output  1  display selects key buffer.
- load_new_a  output  1  one-cycle strobe: alarm register loads key_buffer.
- load_new_c  output  1  one-cycle strobe: current time loads key_buffer.
- shift  output  1  one-cycle strobe: a digit was shifted into key_buffer.

Behaviour:
- Reset (async, reset_n=0):
  - state=SHOW_TIME, key_buffer=0, timeout counter=0, all 1-bit outputs 0.
  - Deassertion is taken synchronously; the first transition is evaluated at the first rising edge after reset_n goes high.
- Outputs are decoded from the state register only; there is no combinational input-to-output path.
- Output decode per state:
  - show_new_time=1 in KEY_STORED, KEY_WAITED and KEY_ENTRY.
  - show_a=1 in SHOW_ALARM.
  - shift=1 in KEY_STORED.
  - load_new_a=1 in SET_ALARM_TIME.
  - load_new_c=1 in SET_CURRENT_TIME.
- Valid digit means key<=9.
- State transitions, evaluated per rising edge. Inputs within a state are checked in the priority order listed:
  - SHOW_TIME: alarm_button -> SHOW_ALARM; valid digit -> KEY_STORED; else stay.
  - KEY_STORED: always -> KEY_WAITED. In the same edge, key_buffer <= {key_buffer[4*DIGITS-5:0], key}; for DIGITS=1 this is key_buffer <= key. The digit is captured on the edge leaving SHOW_TIME/KEY_ENTRY, i.e. the key value present at that edge.
  - KEY_WAITED (waiting for key release): key is not a valid digit -> KEY_ENTRY; timeout -> SHOW_TIME; else stay.
  - KEY_ENTRY: alarm_button -> SET_ALARM_TIME; time_button -> SET_CURRENT_TIME; valid digit -> KEY_STORED; timeout -> SHOW_TIME; else stay.
  - SHOW_ALARM: alarm_button=0 -> SHOW_TIME; else stay.
  - SET_ALARM_TIME and SET_CURRENT_TIME: always -> SHOW_TIME. Each is exactly one cycle, so each strobe is exactly one cycle.
- Timeout counter (8 bits):
  - Cleared in every state except KEY_WAITED and KEY_ENTRY.
  - In those two states, increments on one_second and saturates at TIMEOUT_SEC.
  - timeout = (counter == TIMEOUT_SEC).
  - Each new digit passes through KEY_STORED, which restarts the count.
- Simultaneous events:
  - alarm_button and time_button together in KEY_ENTRY -> alarm wins.
  - A button together with timeout in KEY_ENTRY -> the button wins.
  - A valid digit together with alarm_button in SHOW_TIME -> SHOW_ALARM; the digit is ignored.
- key_buffer is retained after a load and after a timeout. It changes only on shift or reset.
- Reset asserted mid-entry or mid-strobe: immediate return to reset values; no partial strobe survives.

Test Plan:
1. Reset: hold reset_n=0, then release -> state SHOW_TIME; key_buffer=0; show_a, show_new_time, load_new_a, load_new_c, shift all 0.
2. Digit entry and alarm load:
   - Present key=7 for 3 cycles -> shift=1 for exactly 1 cycle; key_buffer=4'h7; show_new_time=1.
   - Set key=NOKEY -> KEY_ENTRY.
   - Pulse alarm_button -> load_new_a=1 for 1 cycle, then show_new_time=0.
3. Time load with DIGITS=2:
   - Enter 1, release, 2, release -> key_buffer=8'h12.
   - Press time_button -> load_new_c=1 for exactly 1 cycle; load_new_a stays 0.
4. Timeout with TIMEOUT_SEC=10:
   - Enter 5 and release; apply 9 one_second pulses -> show_new_time still 1.
   - 10th pulse -> SHOW_TIME one edge later; key_buffer stays 5; no load strobe.
   - Repeat, entering a digit after 9 pulses -> the count restarts.
5. Show alarm: from SHOW_TIME, hold alarm_button 20 cycles with key=3 -> show_a=1 for the whole hold; no shift; show_a=0 one edge after release.
6. Reset during a strobe: assert reset_n=0 in the cycle SET_ALARM_TIME is entered -> load_new_a drops asynchronously; after release, state is SHOW_TIME and key_buffer=0.
